spatz_cluster_barrier: RTL and testbench
========================================

// Module: spatz_cluster_barrier
// PURPOSE
// - Cluster hardware barrier that sits behind the peripheral's HW_BARRIER register (that register always reads 0).
// - Each core issues a barrier request. The block holds every participant's response until all cores in the
//   participation mask have arrived, then releases them together.
// - Sits between the per-core peripheral request demux and the core response path. Exports a completion
//   event and a generation count for perf/debug.
// PARAMETERS
// - NrCores   4   number of requesting harts (>=1)
// - GenWidth  16  width of barrier generation counter
// PORTS
// - clk_i           in   1         cluster clock
// - rst_ni          in   1         async reset, active-low
// - core_mask_i     in   NrCores   participating cores, sampled at the first arrival of each barrier
// - req_valid_i     in   NrCores   core i requests barrier entry
// - req_ready_o     out  NrCores   entry accepted (handshake = valid & ready)
// - rsp_valid_o     out  NrCores   barrier released for core i (response data is always 0, not a port)
// - rsp_ready_i     in   NrCores   core i consumes its response
// - barrier_done_o  out  1         one-cycle pulse when a barrier completes gathering
// - generation_o    out  GenWidth  number of fully released barriers, wraps modulo 2^GenWidth
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, arrived_q/mask_q/bypass_q = 0, generation_q = 0. Reset mid-barrier
//   drops all pending arrivals and responses; no response is issued for requests accepted before reset.
// - Clock and reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
// - State machine: states IDLE, GATHER, RELEASE.
// - Participant set: P = core_mask_i in IDLE, P = mask_q otherwise.
// - Accepting new arrivals:
//   - req_ready_o[i] = 1 in IDLE/GATHER when P[i] and !arrived_q[i]; 0 for participants in RELEASE.
//   - acc = req_valid_i & req_ready_o.
//   - A core holding req_valid_i after arrival is not re-accepted (no double count).
// - IDLE: on acc != 0, mask_q <= core_mask_i and arrived_q <= acc.
//   - If acc == core_mask_i, go to RELEASE; otherwise go to GATHER.
// - GATHER: arrived_q <= arrived_q | acc.
//   - When (arrived_q | acc) == mask_q, go to RELEASE.
//   - Simultaneous arrivals in the same cycle all count.
// - Entry to RELEASE: barrier_done_o = 1 for exactly the cycle the transition is registered.
//   - Latency: last arrival handshake at cycle t -> rsp_valid_o high at cycle t+1.
// - RELEASE: rsp_valid_o = arrived_q.
//   - On rsp_valid_o[i] & rsp_ready_i[i], clear arrived_q[i].
//   - A held rsp_valid_o never drops before its handshake.
//   - When arrived_q reaches 0: go to IDLE, generation_q++ (wraps), mask_q cleared.
//   - A released core re-requesting in RELEASE stalls (ready = 0) until IDLE.
// - Non-participants (bit clear in P):
//   - req_ready_o[i] = !bypass_q[i] in any state.
//   - Accepted request sets bypass_q[i]; rsp_valid_o[i] = 1 the next cycle; cleared on rsp handshake.
//   - Never counted toward a barrier.
// - core_mask_i changes during GATHER/RELEASE are ignored until the next IDLE.
// - core_mask_i == 0: every request uses bypass; the FSM stays in IDLE.
// - NrCores == 1: the single arrival goes IDLE -> RELEASE directly.
// STRUCTURE
// - Shared package spatz_cluster_pkg: typedef enum logic [1:0] {BarIdle, BarGather, BarRelease} barrier_state_e.
// - Flops via common_cells FF macros.
// - No sub-module; mask compare is a plain equality and needs no popcount.
// TESTING
// - NrCores=4, mask=4'hF:
//   - Cores 0, 1, 2 arrive at cycles 1, 3, 5; core 3 arrives at cycle 8.
//   - Required: rsp_valid=4'hF at cycle 9, barrier_done pulse at 9, generation=1 after all four acks.
// - mask=4'hF, all four req_valid asserted in the same cycle:
//   - Required: RELEASE next cycle, single done pulse, generation+1.
// - mask=4'h3, core 2 requests during GATHER:
//   - Required: core 2 bypass response 1 cycle after accept.
//   - Required: barrier completes only after cores 0 and 1.
// - RELEASE with staggered rsp_ready (core 0 acks first, then re-requests):
//   - Required: core 0 req_ready=0 until all acks done.
//   - Required: then accepted in IDLE and starts generation 2.
// - rst_ni asserted during GATHER with arrived=4'h5:
//   - Required: all outputs 0 immediately.
//   - Required: fresh barrier after reset needs all 4 arrivals.
// - GenWidth=2, run 5 barriers:
//   - Required: generation_o sequence 1, 2, 3, 0, 1.
//   - Required: core_mask_i changed mid-GATHER has no effect.

Source files
------------

// File: rtl/spatz_cluster_pkg.sv
// Shared cluster types: barrier controller state encoding.
package spatz_cluster_pkg;

  typedef enum logic [1:0] {
    BarIdle,
    BarGather,
    BarRelease
  } barrier_state_e;

endpackage

// File: rtl/spatz_cluster_barrier.sv
// Cluster hardware barrier: holds participant responses until every masked core
// has arrived, then releases them together; non-participants are bounced straight back.
module spatz_cluster_barrier
  import spatz_cluster_pkg::*;
#(
  parameter int unsigned NrCores  = 4,
  parameter int unsigned GenWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NrCores-1:0]  core_mask_i,
  input  logic [NrCores-1:0]  req_valid_i,
  output logic [NrCores-1:0]  req_ready_o,
  output logic [NrCores-1:0]  rsp_valid_o,
  input  logic [NrCores-1:0]  rsp_ready_i,
  output logic                barrier_done_o,
  output logic [GenWidth-1:0] generation_o
);

  barrier_state_e      state_q, state_d;
  logic [NrCores-1:0]  arrived_q, arrived_d;
  logic [NrCores-1:0]  mask_q, mask_d;
  logic [NrCores-1:0]  bypass_q, bypass_d;
  logic [GenWidth-1:0] gen_q, gen_d;
  logic                done_q, done_d;

  logic [NrCores-1:0]  part;
  logic [NrCores-1:0]  ready;
  logic [NrCores-1:0]  rsp_valid;
  logic [NrCores-1:0]  acc;
  logic [NrCores-1:0]  acc_part;
  logic [NrCores-1:0]  acc_byp;
  logic [NrCores-1:0]  rsp_hs;
  logic                in_release;

  // The mask is live only while idle; once a barrier opens the latched copy rules.
  assign part       = (state_q == BarIdle) ? core_mask_i : mask_q;
  assign in_release = (state_q == BarRelease);

  // Participants enter once per barrier and never during release; others bounce when free.
  assign ready = (part & ~arrived_q & ~bypass_q & {NrCores{~in_release}})
               | (~part & ~bypass_q);

  assign rsp_valid = bypass_q | (arrived_q & {NrCores{in_release}});

  assign acc      = req_valid_i & ready;
  assign acc_part = acc & part;
  assign acc_byp  = acc & ~part;
  assign rsp_hs   = rsp_valid & rsp_ready_i;

  // Next-state and bookkeeping for the barrier FSM.
  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    mask_d    = mask_q;
    gen_d     = gen_q;
    done_d    = 1'b0;
    bypass_d  = (bypass_q & ~rsp_hs) | acc_byp;

    unique case (state_q)
      BarIdle: begin
        if (acc_part != '0) begin
          mask_d    = core_mask_i;
          arrived_d = acc_part;
          if (acc_part == core_mask_i) begin
            state_d = BarRelease;
            done_d  = 1'b1;
          end else begin
            state_d = BarGather;
          end
        end
      end
      BarGather: begin
        arrived_d = arrived_q | acc_part;
        if ((arrived_q | acc_part) == mask_q) begin
          state_d = BarRelease;
          done_d  = 1'b1;
        end
      end
      BarRelease: begin
        arrived_d = arrived_q & ~rsp_hs;
        if ((arrived_q & ~rsp_hs) == '0) begin
          state_d = BarIdle;
          mask_d  = '0;
          gen_d   = gen_q + GenWidth'(1);
        end
      end
      default: begin
        state_d = BarIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= BarIdle;
      arrived_q <= '0;
      mask_q    <= '0;
      bypass_q  <= '0;
      gen_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      mask_q    <= mask_d;
      bypass_q  <= bypass_d;
      gen_q     <= gen_d;
      done_q    <= done_d;
    end
  end

  // Entry is suppressed while reset is held so every output reads 0.
  assign req_ready_o    = ready & {NrCores{rst_ni}};
  assign rsp_valid_o    = rsp_valid;
  assign barrier_done_o = done_q;
  assign generation_o   = gen_q;

endmodule

// File: tb/tb_spatz_cluster_barrier.sv
// Bench for spatz_cluster_barrier: directed vector table, hand sequences and
// randomized traffic against a set-based reference model.
module tb_spatz_cluster_barrier;

  localparam int unsigned N  = 4;
  localparam int unsigned GW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  core_mask;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic          barrier_done;
  logic [GW-1:0] generation;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: who is waiting, who holds a bounce, whether a barrier is open/releasing.
  logic         open_b;
  logic         releasing;
  logic [N-1:0] waiting;
  logic [N-1:0] byp;
  logic [N-1:0] mask_m;
  logic         done_m;
  int           gen_m;

  logic [N-1:0]  obs_ready;
  logic [N-1:0]  obs_rsp;
  logic          obs_done;
  logic [GW-1:0] obs_gen;

  typedef struct packed {
    logic [N-1:0]  mask;
    logic [N-1:0]  valid;
    logic [N-1:0]  rrdy;
    logic [N-1:0]  ready;
    logic [N-1:0]  rsp;
    logic          done;
    logic [GW-1:0] gen;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  spatz_cluster_barrier #(
    .NrCores  (N),
    .GenWidth (GW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .core_mask_i    (core_mask),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .barrier_done_o (barrier_done),
    .generation_o   (generation)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [N-1:0] m_part();
    return open_b ? mask_m : core_mask;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] p;
    logic [N-1:0] r;
    p = m_part();
    for (int i = 0; i < N; i++) begin
      if (p[i]) r[i] = !releasing && !waiting[i] && !byp[i];
      else      r[i] = !byp[i];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] m_rsp();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = byp[i] || (releasing && waiting[i]);
    return r;
  endfunction

  task automatic model_reset();
    open_b    = 1'b0;
    releasing = 1'b0;
    waiting   = '0;
    byp       = '0;
    mask_m    = '0;
    done_m    = 1'b0;
    gen_m     = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] p, acc, hs, arrivals, bounces;
    p        = m_part();
    acc      = req_valid & m_ready();
    hs       = m_rsp() & rsp_ready;
    arrivals = acc & p;
    bounces  = acc & ~p;
    done_m   = 1'b0;
    if (releasing) begin
      waiting = waiting & ~hs;
      if (waiting == '0) begin
        releasing = 1'b0;
        open_b    = 1'b0;
        mask_m    = '0;
        gen_m     = (gen_m + 1) % (1 << GW);
      end
    end else begin
      if (!open_b && arrivals != '0) begin
        open_b = 1'b1;
        mask_m = core_mask;
      end
      waiting = waiting | arrivals;
      if (open_b && waiting == mask_m) begin
        releasing = 1'b1;
        done_m    = 1'b1;
      end
    end
    byp = (byp & ~hs) | bounces;
  endtask

  // One clock: sample and compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    obs_ready = req_ready;
    obs_rsp   = rsp_valid;
    obs_done  = barrier_done;
    obs_gen   = generation;
    chk("req_ready", 32'(obs_ready), 32'(m_ready()));
    chk("rsp_valid", 32'(obs_rsp), 32'(m_rsp()));
    chk("barrier_done", 32'(obs_done), 32'(done_m));
    chk("generation", 32'(obs_gen), 32'(gen_m));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] m, input logic [N-1:0] v, input logic [N-1:0] r);
    core_mask = m;
    req_valid = v;
    rsp_ready = r;
  endtask

  initial begin
    logic [GW-1:0] gen_seq [4];
    gen_seq[0] = 2'd2; gen_seq[1] = 2'd3; gen_seq[2] = 2'd0; gen_seq[3] = 2'd1;

    //            mask   valid  rrdy   ready  rsp    done  gen
    vecs[0]  = '{4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 2'd0};
    vecs[1]  = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1, 2'd0};
    vecs[2]  = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 1'b0, 2'd0};
    vecs[3]  = '{4'h3, 4'h4, 4'h0, 4'hF, 4'h0, 1'b0, 2'd1};
    vecs[4]  = '{4'h3, 4'h1, 4'h0, 4'hB, 4'h4, 1'b0, 2'd1};
    vecs[5]  = '{4'h3, 4'h1, 4'h4, 4'hA, 4'h4, 1'b0, 2'd1};
    vecs[6]  = '{4'hF, 4'h6, 4'h0, 4'hE, 4'h0, 1'b0, 2'd1};
    vecs[7]  = '{4'hF, 4'h0, 4'h0, 4'h8, 4'h7, 1'b1, 2'd1};
    vecs[8]  = '{4'hF, 4'h0, 4'h1, 4'h8, 4'h7, 1'b0, 2'd1};
    vecs[9]  = '{4'hF, 4'h1, 4'h4, 4'h8, 4'h6, 1'b0, 2'd1};
    vecs[10] = '{4'hF, 4'h1, 4'h2, 4'hC, 4'h2, 1'b0, 2'd1};
    vecs[11] = '{4'hF, 4'h1, 4'h0, 4'hF, 4'h0, 1'b0, 2'd2};
    vecs[12] = '{4'hF, 4'h5, 4'h0, 4'hE, 4'h0, 1'b0, 2'd2};

    rst_n = 1'b0;
    drive(4'hF, 4'h0, 4'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(req_ready), 32'h0);
    chk("reset rsp", 32'(rsp_valid), 32'h0);
    chk("reset done", 32'(barrier_done), 32'h0);
    chk("reset gen", 32'(generation), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: full-mask barrier, bypass during gather, staggered acks, re-request.
    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].mask, vecs[k].valid, vecs[k].rrdy);
      cycle();
      chk($sformatf("vec%0d ready", k), 32'(obs_ready), 32'(vecs[k].ready));
      chk($sformatf("vec%0d rsp", k), 32'(obs_rsp), 32'(vecs[k].rsp));
      chk($sformatf("vec%0d done", k), 32'(obs_done), 32'(vecs[k].done));
      chk($sformatf("vec%0d gen", k), 32'(obs_gen), 32'(vecs[k].gen));
    end

    // Reset while gathering with cores 0 and 2 arrived.
    rst_n = 1'b0;
    #1;
    chk("midreset ready", 32'(req_ready), 32'h0);
    chk("midreset rsp", 32'(rsp_valid), 32'h0);
    chk("midreset done", 32'(barrier_done), 32'h0);
    chk("midreset gen", 32'(generation), 32'h0);
    model_reset();
    drive(4'hF, 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Staggered arrivals: 0,1,2 at cycles 1,3,5, core 3 at cycle 8.
    for (int c = 0; c < 10; c++) begin
      case (c)
        1:       drive(4'hF, 4'h1, 4'h0);
        3:       drive(4'hF, 4'h2, 4'h0);
        5:       drive(4'hF, 4'h4, 4'h0);
        8:       drive(4'hF, 4'h8, 4'h0);
        default: drive(4'hF, 4'h0, 4'h0);
      endcase
      cycle();
      if (c == 7) chk("stagger held c7", 32'(obs_rsp), 32'h0);
      if (c == 8) chk("stagger done c8", 32'(obs_done), 32'h0);
      if (c == 9) begin
        chk("stagger rsp c9", 32'(obs_rsp), 32'hF);
        chk("stagger done c9", 32'(obs_done), 32'h1);
      end
    end
    drive(4'hF, 4'h0, 4'hF);
    cycle();
    drive(4'hF, 4'h0, 4'h0);
    cycle();
    chk("stagger gen", 32'(obs_gen), 32'h1);
    chk("stagger done cleared", 32'(obs_done), 32'h0);

    // Generation wrap with the mask disturbed mid-gather.
    for (int k = 0; k < 4; k++) begin
      drive(4'hF, 4'h3, 4'h0);
      cycle();
      drive((k % 2 == 1) ? 4'h1 : 4'h5, 4'h0, 4'h0);
      cycle();
      chk($sformatf("wrap%0d hold", k), 32'(obs_rsp), 32'h0);
      drive(core_mask, 4'hC, 4'h0);
      cycle();
      drive(core_mask, 4'h0, 4'h0);
      cycle();
      chk($sformatf("wrap%0d rsp", k), 32'(obs_rsp), 32'hF);
      drive(core_mask, 4'h0, 4'hF);
      cycle();
      drive(4'hF, 4'h0, 4'h0);
      cycle();
      chk($sformatf("wrap%0d gen", k), 32'(obs_gen), 32'(gen_seq[k]));
    end

    // Randomized traffic, mask occasionally reshuffled.
    drive(4'hF, 4'h0, 4'h0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) core_mask = N'($urandom_range(0, 15));
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
